// File: rtl/multiplier_booth_seq_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
// Optional feature macro used by this slice: MUL_UNSIGNED_EN.
package multiplier_booth_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam int REG_SIZE_DEF = 32;

  // Counter must reach REG_SIZE when the unsigned mode adds its extra step.
  function automatic int cnt_width(input int reg_size);
    return $clog2(reg_size + 2);
  endfunction

  localparam int CNT_W = cnt_width(REG_SIZE_DEF);

endpackage

// File: rtl/multiplier_booth_seq_if.sv
// Start/Busy/Done handshake and operand/result bus between control unit and multiplier.
// MUL_UNSIGNED_EN adds the Signed_Mode request bit.
interface multiplier_booth_seq_if
  import multiplier_booth_seq_pkg::*;
#(
  parameter int REG_SIZE = REG_SIZE_DEF
);

  logic                    Start;
  logic [REG_SIZE-1:0]     Multiplicand;
  logic [REG_SIZE-1:0]     Multiplier;
  logic                    Busy;
  logic                    Done;
  logic [2*REG_SIZE-1:0]   Z_Out;
`ifdef MUL_UNSIGNED_EN
  logic                    Signed_Mode;
`endif

  modport master (
    output Start,
    output Multiplicand,
    output Multiplier,
`ifdef MUL_UNSIGNED_EN
    output Signed_Mode,
`endif
    input  Busy,
    input  Done,
    input  Z_Out
  );

  modport slave (
    input  Start,
    input  Multiplicand,
    input  Multiplier,
`ifdef MUL_UNSIGNED_EN
    input  Signed_Mode,
`endif
    output Busy,
    output Done,
    output Z_Out
  );

endinterface

// File: rtl/multiplier_booth_seq_booth_step.sv
// One radix-2 Booth iteration: add/subtract/hold on A, then arithmetic
// shift right of {A, Q, Q_-1}.
module booth_step
  import multiplier_booth_seq_pkg::*;
#(
  parameter int REG_SIZE = REG_SIZE_DEF
) (
  input  logic [REG_SIZE:0]   a_i,
  input  logic [REG_SIZE:0]   m_i,
  input  logic [REG_SIZE-1:0] q_i,
  input  logic                qm1_i,
  input  logic                zero_q0_i,
  output logic [REG_SIZE:0]   a_o,
  output logic [REG_SIZE-1:0] q_o,
  output logic                qm1_o
);

  logic              q0_sel;
  logic [REG_SIZE:0] sum;

  // zero_q0_i stands in for the zero-extension bit of an unsigned multiplier
  // once all REG_SIZE real multiplier bits have been consumed.
  assign q0_sel = q_i[0] & ~zero_q0_i;

  always_comb begin
    sum = a_i;
    case ({q0_sel, qm1_i})
      2'b01:   sum = a_i + m_i;
      2'b10:   sum = a_i - m_i;
      default: sum = a_i;
    endcase
  end

  assign {a_o, q_o, qm1_o} = {sum[REG_SIZE], sum, q_i};

endmodule

// File: rtl/multiplier_booth_seq.sv
// Sequential radix-2 Booth multiplier, one step per clock, Z_Out = {HI, LO}.
// MUL_UNSIGNED_EN adds an unsigned mode taking one extra step.
module multiplier_booth_seq
  import multiplier_booth_seq_pkg::*;
#(
  parameter int REG_SIZE = REG_SIZE_DEF
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  multiplier_booth_seq_if.slave bus
);

  localparam int CW = cnt_width(REG_SIZE);

  state_t                state_q, state_d;
  logic [REG_SIZE:0]     a_q, a_d;
  logic [REG_SIZE:0]     m_q, m_d;
  logic [REG_SIZE-1:0]   q_q, q_d;
  logic                  qm1_q, qm1_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2*REG_SIZE-1:0] z_q, z_d;

  logic [REG_SIZE:0]     a_nx;
  logic [REG_SIZE-1:0]   q_nx;
  logic                  qm1_nx;
  logic                  zero_q0;
  logic [CW-1:0]         last_idx;
  logic [2*REG_SIZE-1:0] result;
  logic                  uns_load;

`ifdef MUL_UNSIGNED_EN
  logic uns_q, uns_d;

  assign uns_load = ~bus.Signed_Mode;
  assign zero_q0  = uns_q && (cnt_q == CW'(REG_SIZE));
  assign last_idx = uns_q ? CW'(REG_SIZE) : CW'(REG_SIZE - 1);
  // Unsigned runs one step further, so the product sits one bit lower and
  // the final bit ends up in Q_-1.
  assign result   = uns_q ? {a_nx[REG_SIZE-2:0], q_nx, qm1_nx}
                          : {a_nx[REG_SIZE-1:0], q_nx};
`else
  assign uns_load = 1'b0;
  assign zero_q0  = 1'b0;
  assign last_idx = CW'(REG_SIZE - 1);
  assign result   = {a_nx[REG_SIZE-1:0], q_nx};
`endif

  booth_step #(.REG_SIZE(REG_SIZE)) u_step (
    .a_i       (a_q),
    .m_i       (m_q),
    .q_i       (q_q),
    .qm1_i     (qm1_q),
    .zero_q0_i (zero_q0),
    .a_o       (a_nx),
    .q_o       (q_nx),
    .qm1_o     (qm1_nx)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    m_d     = m_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
`ifdef MUL_UNSIGNED_EN
    uns_d   = uns_q;
`endif

    case (state_q)
      IDLE, FINISH: begin
        state_d = IDLE;
        if (bus.Start) begin
          state_d = RUN;
          a_d     = '0;
          m_d     = uns_load ? {1'b0, bus.Multiplicand}
                             : {bus.Multiplicand[REG_SIZE-1], bus.Multiplicand};
          q_d     = bus.Multiplier;
          qm1_d   = 1'b0;
          cnt_d   = '0;
`ifdef MUL_UNSIGNED_EN
          uns_d   = uns_load;
`endif
        end
      end
      RUN: begin
        a_d   = a_nx;
        q_d   = q_nx;
        qm1_d = qm1_nx;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == last_idx) begin
          z_d     = result;
          state_d = FINISH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      z_q     <= '0;
`ifdef MUL_UNSIGNED_EN
      uns_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
`ifdef MUL_UNSIGNED_EN
      uns_q   <= uns_d;
`endif
    end
  end

  assign bus.Busy  = (state_q == RUN);
  assign bus.Done  = (state_q == FINISH);
  assign bus.Z_Out = z_q;

endmodule
